// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU sequencer: op encoding, FSM states, default latencies.
// Ops 9..15 fall outside every decode below and so behave as NONE.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU signal bundle. The Flush input exists only when MDU_FLUSH_EN is defined.
interface mdu_ctrl_if;

  logic [3:0]  MDUOp_E;
  logic        MDUStart_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        MDUUse_D;
`ifdef MDU_FLUSH_EN
  logic        Flush;
`endif
  logic        Busy;
  logic        Stall_MDU;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut_E;

  // Pipeline side: drives op/operands, observes stall and results.
  modport master (
`ifdef MDU_FLUSH_EN
    output Flush,
`endif
    output MDUOp_E, MDUStart_E, A_E, B_E, MDUUse_D,
    input  Busy, Stall_MDU, HI, LO, MDUOut_E
  );

  modport slave (
`ifdef MDU_FLUSH_EN
    input  Flush,
`endif
    input  MDUOp_E, MDUStart_E, A_E, B_E, MDUUse_D,
    output Busy, Stall_MDU, HI, LO, MDUOut_E
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit MULT/MULTU/DIV/DIVU result generator working on latched operands.
// Signed division goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] divisor;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic               a_neg;
  logic               b_neg;

  always_comb begin
    a_sx   = $signed({{32{a[31]}}, a});
    b_sx   = $signed({{32{b[31]}}, b});
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};

    a_neg = (op == OP_DIV) && a[31];
    b_neg = (op == OP_DIV) && b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;

    // Divisor of zero is replaced by one only to keep the divider defined; the result is discarded.
    div_zero = is_div_op(op) && (b == 32'd0);
    divisor  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: IDLE/BUSY FSM with latency counter, HI/LO ownership, MF/MT service and stall.
// Optional MDU_FLUSH_EN adds a Flush input that aborts in-flight ops and suppresses IDLE writes.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_p0;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;
  logic             flush;
  logic             start_ok;

`ifdef MDU_FLUSH_EN
  assign flush = bus.Flush;
`else
  assign flush = 1'b0;
`endif

  assign start_ok = bus.MDUStart_E && is_start_op(bus.MDUOp_E);

  mdu_arith u_arith (
    .op       (op_p0),
    .a        (a_p0),
    .b        (b_p0),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_p0 <= OP_NONE;
      a_p0  <= '0;
      b_p0  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush) begin
            if (start_ok) begin
              // ---- stage p0: operands and op captured for the whole busy window ----
              op_p0 <= bus.MDUOp_E;
              a_p0  <= bus.A_E;
              b_p0  <= bus.B_E;
              cnt   <= is_div_op(bus.MDUOp_E) ? DIV_LOAD : MULT_LOAD;
              state <= ST_BUSY;
            end else if (bus.MDUOp_E == OP_MTHI) begin
              hi_q <= bus.A_E;
            end else if (bus.MDUOp_E == OP_MTLO) begin
              lo_q <= bus.A_E;
            end
          end
        end
        ST_BUSY: begin
          // Any start or MT arriving here is ignored; flush beats completion.
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_ONE) begin
            if (!div_zero) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.Busy      = (state == ST_BUSY);
  assign bus.Stall_MDU = bus.MDUUse_D && ((state == ST_BUSY) || bus.MDUStart_E);
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

  always_comb begin
    bus.MDUOut_E = 32'd0;
    if (bus.MDUOp_E == OP_MFHI)      bus.MDUOut_E = hi_q;
    else if (bus.MDUOp_E == OP_MFLO) bus.MDUOut_E = lo_q;
  end

endmodule
